prog_timer: RTL and testbench
=============================

// Module: prog_timer
// PURPOSE
//  Programmable up-counting timer; single clock domain with a clock-enable prescaler, not a derived clock.
//  Divides clk to a tick, counts ticks, and on compare match either auto-reloads (periodic) or stops (one-shot).
//  Raises a sticky interrupt on match. Sits on the processor peripheral side: CPU writes config, reads count/irq.
// PARAMETERS
//  WIDTH     16     counter/compare/reload width in bits
//  PRESC_W   17     prescaler counter width in bits
//  PRESC_RST 75000  prescaler divide value loaded at reset (tick every PRESC_RST+1 clk)
// PORTS
//  clk          in   1        system clock; all state on posedge clk
//  rst          in   1        asynchronous, active-high reset
//  cfg_wr       in   1        1-cycle strobe: latch all cfg_* inputs, restart timer
//  cfg_enable   in   1        1 = run after cfg_wr, 0 = stopped
//  cfg_oneshot  in   1        1 = stop at match, 0 = reload at match
//  cfg_presc    in   PRESC_W  prescaler divide value (tick every cfg_presc+1 clk)
//  cfg_reload   in   WIDTH    start/reload value for count
//  cfg_compare  in   WIDTH    match value
//  irq_ack      in   1        1-cycle strobe: clear irq
//  count        out  WIDTH    current count (registered)
//  tick         out  1        1-cycle pulse per prescaler period while running
//  running      out  1        timer active
//  irq          out  1        sticky match flag
//  cap_in       in   1        async capture input (used only with TIMER_CAPTURE_EN)
//  cap_val      out  WIDTH    captured count
//  cap_stb      out  1        1-cycle pulse when cap_val updates
// BEHAVIOUR
//  Reset: presc value=PRESC_RST, reload=0, compare={WIDTH{1}}, oneshot=0, prescaler cnt=0,
//    count=0, tick=0, running=0, irq=0, cap_val=0, cap_stb=0. Reset mid-count aborts immediately.
//  Prescaler: while running, pcnt increments each clk; when pcnt==presc value, pcnt<=0, tick=1 next cycle.
//    presc value 0 -> tick every clk. Not running: pcnt held at 0, tick=0.
//  Count update on tick edge (registered, visible 1 clk after the prescaler wrap):
//    count!=compare -> count<=count+1, wrap {WIDTH{1}} -> 0 silently.
//    count==compare -> irq<=1; periodic: count<=reload; one-shot: count held, running<=0.
//    reload==compare periodic: match on every tick, count stays at reload.
//  cfg_wr: latch cfg_*; count<=cfg_reload; pcnt<=0; running<=cfg_enable; pending tick discarded.
//    cfg_wr on same cycle as tick wrap: cfg_wr wins, no increment, no match. irq not cleared by cfg_wr.
//  States: IDLE (running=0) -> RUN on cfg_wr with cfg_enable=1; RUN -> IDLE on one-shot match
//    or cfg_wr with cfg_enable=0; IDLE->IDLE on cfg_wr with enable=0.
//  irq: set on match, cleared by irq_ack; match and irq_ack same cycle -> irq stays 1.
// CONFIGURATION
//  TIMER_CAPTURE_EN defined: cap_in through 2-FF synchroniser, rising edge detected; on edge
//    cap_val<=count and cap_stb=1 for one clk; cap_stb 3 clk after cap_in rise; edge coincident with
//    count update captures pre-update count. Capture works whether or not running.
//  TIMER_CAPTURE_EN undefined: no synchroniser logic; cap_in ignored; cap_val=0, cap_stb=0 constantly.
// TESTING
//  1 rst pulse -> count=0, running=0, irq=0, tick=0; pcnt reset so first tick after PRESC_RST+1 clk.
//  2 cfg_wr presc=3 reload=5 compare=8 periodic en=1 -> tick every 4 clk; count 5,6,7,8,5,...; irq set
//    on tick at count 8; irq_ack clears; ack coincident with next match leaves irq=1.
//  3 cfg_wr presc=0 reload=0 compare=2 oneshot en=1 -> count 0,1,2 then holds 2, running=0, tick stops.
//  4 WIDTH=4 compare=4'hF? no: compare=3 reload=14 periodic presc=0 -> count 14,15,0,1,2,3,14 (wrap).
//  5 cfg_wr issued on exact tick-wrap cycle with reload=9 -> count=9, no increment, pcnt restarts at 0;
//    rst asserted mid-count -> all outputs to reset values same cycle.
//  6 TIMER_CAPTURE_EN: cap_in rise while count=7 steady -> cap_val=7, cap_stb 1 clk, 3 clk after rise;
//    undefined: cap_in toggling -> cap_val=0, cap_stb=0.

Source files
------------

// File: rtl/prog_timer.sv
// prog_timer: programmable up-counting timer with a clock-enable prescaler.
//
// The prescaler divides clk into a one-cycle tick; each tick advances count.
// When count equals the compare value the timer raises a sticky irq and then
// either reloads (periodic) or stops holding count (one-shot). A CPU-side
// write strobe (cfg_wr) latches every cfg_* input and restarts the timer.
//
// Optional feature: define TIMER_CAPTURE_EN to enable the input-capture
// unit (cap_in -> 2-FF synchroniser -> rising-edge capture of count).
// Without it cap_in is ignored and cap_val/cap_stb are held at zero.
//
// Ports:
//   clk          in   system clock, all state on posedge
//   rst          in   asynchronous active-high reset
//   cfg_wr       in   one-cycle strobe: latch cfg_*, restart timer
//   cfg_enable   in   1 = run after cfg_wr, 0 = stopped
//   cfg_oneshot  in   1 = stop at match, 0 = reload at match
//   cfg_presc    in   prescaler divide value (tick every cfg_presc+1 clk)
//   cfg_reload   in   start/reload value for count
//   cfg_compare  in   match value
//   irq_ack      in   one-cycle strobe: clear irq
//   count        out  current count (registered)
//   tick         out  one-cycle pulse per prescaler period while running
//   running      out  timer active; this is also the FSM state (RUN=1)
//   irq          out  sticky match flag
//   cap_in       in   asynchronous capture input
//   cap_val      out  captured count
//   cap_stb      out  one-cycle pulse when cap_val updates
//
// Handshake: there is no valid/ready pair; cfg_wr and irq_ack are single-cycle
// strobes that are acted on at the clock edge where they are sampled high,
// and tick/cap_stb are single-cycle qualifiers for count/cap_val.

module prog_timer #(
    parameter int WIDTH     = 16,
    parameter int PRESC_W   = 17,
    parameter int PRESC_RST = 75000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic               cfg_enable,
    input  logic               cfg_oneshot,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic [WIDTH-1:0]   cfg_reload,
    input  logic [WIDTH-1:0]   cfg_compare,
    input  logic               irq_ack,
    output logic [WIDTH-1:0]   count,
    output logic               tick,
    output logic               running,
    output logic               irq,
    input  logic               cap_in,
    output logic [WIDTH-1:0]   cap_val,
    output logic               cap_stb
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [PRESC_W-1:0] PRESC_INIT = PRESC_W'(PRESC_RST);

    logic [0:0]         state;
    logic [PRESC_W-1:0] presc_val;
    logic [PRESC_W-1:0] pcnt;
    logic [WIDTH-1:0]   reload_val;
    logic [WIDTH-1:0]   compare_val;
    logic               oneshot;
    logic               wrap;
    logic               match;

    assign running = (state == RUN);

    // wrap is the prescaler terminal cycle; the count update happens on the
    // same edge, so count and tick become visible together one clk later.
    assign wrap  = (state == RUN) && (pcnt == presc_val);
    assign match = wrap && (count == compare_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            presc_val   <= PRESC_INIT;
            reload_val  <= '0;
            compare_val <= '1;
            oneshot     <= 1'b0;
            pcnt        <= '0;
            count       <= '0;
            tick        <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (cfg_wr) begin
                // A write always wins over a coincident wrap: the pending
                // tick, increment and match are all discarded.
                presc_val   <= cfg_presc;
                reload_val  <= cfg_reload;
                compare_val <= cfg_compare;
                oneshot     <= cfg_oneshot;
                count       <= cfg_reload;
                pcnt        <= '0;
                state       <= cfg_enable ? RUN : IDLE;
            end else if (state == RUN) begin
                if (wrap) begin
                    pcnt <= '0;
                    tick <= 1'b1;
                    if (count == compare_val) begin
                        if (oneshot) begin
                            state <= IDLE;
                        end else begin
                            count <= reload_val;
                        end
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    pcnt <= pcnt + PRESC_W'(1);
                end
            end else begin
                pcnt <= '0;
            end
        end
    end

    // Set has priority over ack so a match is never lost. cfg_wr suppresses
    // the match but leaves irq itself alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (match && !cfg_wr) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic cap_s1;
    logic cap_s2;
    logic cap_prev;
    logic cap_edge;

    assign cap_edge = cap_s2 && !cap_prev;

    // Samples count before any update on the same edge, so a capture that
    // coincides with a tick records the pre-update value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_s1   <= 1'b0;
            cap_s2   <= 1'b0;
            cap_prev <= 1'b0;
            cap_val  <= '0;
            cap_stb  <= 1'b0;
        end else begin
            cap_s1   <= cap_in;
            cap_s2   <= cap_s1;
            cap_prev <= cap_s2;
            cap_stb  <= cap_edge;
            if (cap_edge) begin
                cap_val <= count;
            end
        end
    end
`else
    logic unused_cap_in;

    assign unused_cap_in = cap_in;
    assign cap_val       = '0;
    assign cap_stb       = 1'b0;
`endif

endmodule

// File: tb/tb_prog_timer.sv
module tb_prog_timer;

    localparam int W  = 4;
    localparam int PW = 8;
    localparam int PR = 5;

    // clock / reset
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_wr = 1'b0;
    logic          cfg_enable = 1'b0;
    logic          cfg_oneshot = 1'b0;
    logic [PW-1:0] cfg_presc = '0;
    logic [W-1:0]  cfg_reload = '0;
    logic [W-1:0]  cfg_compare = '0;
    logic          irq_ack = 1'b0;
    logic [W-1:0]  count;
    logic          tick;
    logic          running;
    logic          irq;
    logic          cap_in = 1'b0;
    logic [W-1:0]  cap_val;
    logic          cap_stb;

    initial forever #5 clk = ~clk;

    prog_timer #(.WIDTH(W), .PRESC_W(PW), .PRESC_RST(PR)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr(cfg_wr), .cfg_enable(cfg_enable), .cfg_oneshot(cfg_oneshot),
        .cfg_presc(cfg_presc), .cfg_reload(cfg_reload), .cfg_compare(cfg_compare),
        .irq_ack(irq_ack),
        .count(count), .tick(tick), .running(running), .irq(irq),
        .cap_in(cap_in), .cap_val(cap_val), .cap_stb(cap_stb)
    );

    int checks = 0;
    int failures = 0;
    // entries: {irq, running, count} expected at each tick
    logic [W+1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // driver tasks
    task automatic push(input logic i, input logic r, input logic [W-1:0] c);
        exp_q.push_back({i, r, c});
    endtask

    task automatic do_cfg(input logic en, input logic os, input logic [PW-1:0] p,
                          input logic [W-1:0] rl, input logic [W-1:0] cp);
        cfg_enable  = en;
        cfg_oneshot = os;
        cfg_presc   = p;
        cfg_reload  = rl;
        cfg_compare = cp;
        cfg_wr      = 1'b1;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack;
        irq_ack = 1'b1;
        cycles(1);
        irq_ack = 1'b0;
    endtask

    // scoreboard monitor: every tick must match the next expected entry
    always @(negedge clk) begin
        if (rst === 1'b0 && tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tick actual count=%0h required no tick at %0t", count, $time);
            end else begin
                check("tick_state", {irq, running, count}, exp_q.pop_front());
            end
        end
    end

    task automatic report;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        report();
        $finish;
    end

    initial begin
        // reset state
        cycles(3);
        check("rst_count", count, 0);
        check("rst_running", running, 0);
        check("rst_irq", irq, 0);
        check("rst_tick", tick, 0);
        check("rst_cap_val", cap_val, 0);
        check("rst_cap_stb", cap_stb, 0);
        rst = 1'b0;
        cycles(4);
        check("idle_count", count, 0);
        check("idle_tick", tick, 0);

        // periodic presc=3 reload=5 compare=8; ticks at E4,E8,...
        push(0, 1, 6); push(0, 1, 7); push(0, 1, 8); push(1, 1, 5);
        push(0, 1, 6); push(0, 1, 7); push(0, 1, 8); push(1, 1, 5);
        do_cfg(1, 0, 3, 5, 8);
        check("p_start_count", count, 5);
        check("p_start_running", running, 1);
        cycles(17);
        ack();                                   // sampled at E18, no match
        check("p_ack_clears", irq, 0);
        cycles(13);
        ack();                                   // sampled at E32 with a match
        check("p_ack_vs_match", irq, 1);
        do_cfg(0, 0, 3, 5, 8);
        check("p_stop_running", running, 0);
        check("p_stop_count", count, 5);
        check("p_cfg_keeps_irq", irq, 1);
        check("p_queue_empty", exp_q.size(), 0);
        ack();
        check("p_irq_cleared", irq, 0);

        // one-shot presc=0 reload=0 compare=2
        push(0, 1, 1); push(0, 1, 2); push(1, 0, 2);
        do_cfg(1, 1, 0, 0, 2);
        cycles(12);
        check("os_count_held", count, 2);
        check("os_running", running, 0);
        check("os_tick", tick, 0);
        check("os_irq", irq, 1);
        check("os_queue_empty", exp_q.size(), 0);
        ack();
        check("os_irq_cleared", irq, 0);

        // wrap-around: reload=14 compare=3 periodic presc=0
        push(0, 1, 15); push(0, 1, 0); push(0, 1, 1);
        push(0, 1, 2); push(0, 1, 3); push(1, 1, 14);
        do_cfg(1, 0, 0, 14, 3);
        cycles(6);
        do_cfg(0, 0, 0, 14, 3);                  // sampled at E7, would-be tick discarded
        check("wr_queue_empty", exp_q.size(), 0);
        check("wr_count", count, 14);
        check("wr_running", running, 0);
        ack();
        check("wr_irq_cleared", irq, 0);

        // cfg_wr on the exact wrap cycle, then async reset mid-count
        push(0, 1, 1); push(0, 1, 10);
        do_cfg(1, 0, 3, 0, 15);
        cycles(7);
        do_cfg(1, 0, 3, 9, 15);                  // sampled at E8 (wrap)
        check("cw_count", count, 9);
        check("cw_tick", tick, 0);
        cycles(3);
        check("cw_no_early_tick", tick, 0);
        check("cw_count_hold", count, 9);
        cycles(1);
        check("cw_tick_restart", tick, 1);
        check("cw_count_inc", count, 10);
        #5;
        rst = 1'b1;
        #1;
        check("ar_count", count, 0);
        check("ar_running", running, 0);
        check("ar_tick", tick, 0);
        check("ar_irq", irq, 0);
        check("ar_queue_empty", exp_q.size(), 0);
        cycles(1);
        rst = 1'b0;
        cycles(1);

`ifdef TIMER_CAPTURE_EN
        do_cfg(0, 0, 0, 7, 15);
        check("cap_count_steady", count, 7);
        cap_in = 1'b1;
        cycles(1);
        check("cap_stb_e1", cap_stb, 0);
        cycles(1);
        check("cap_stb_e2", cap_stb, 0);
        cycles(1);
        check("cap_stb_e3", cap_stb, 1);
        check("cap_val", cap_val, 7);
        cycles(1);
        check("cap_stb_e4", cap_stb, 0);
        cap_in = 1'b0;
`else
        for (int i = 0; i < 8; i++) begin
            cap_in = ~cap_in;
            cycles(1);
            check("nocap_val", cap_val, 0);
            check("nocap_stb", cap_stb, 0);
        end
`endif

        cycles(2);
        check("final_queue_empty", exp_q.size(), 0);
        report();
        $finish;
    end

endmodule
